mem_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory bus between the core's instruction-fetch port and data-access port.
- Sits between the openmips top (rom_* / ram_* ports) and the unified SRAM/bus controller.
- Converts each port's request into a req/ack bus transaction and raises per-port stall requests toward ctrl until that port's data has been consumed.
- Drains and discards in-flight transactions on an exception flush.

---
 rtl/mem_arbiter_pkg.sv | 48 ++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_arbiter_pkg;

    localparam int unsigned REG_BUS_W   = 32;
    localparam int unsigned ARB_STATE_W = 2;
    localparam int unsigned SEL_W       = 4;

    localparam logic [SEL_W-1:0] FETCH_SEL = 4'hF;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IBUS  = 2'd1,
        ARB_DBUS  = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                 we;
        logic [SEL_W-1:0]     sel;
        logic [REG_BUS_W-1:0] addr;
        logic [REG_BUS_W-1:0] wdata;
    } bus_cmd_t;

    // Instruction fetches are always full-word reads.
    function automatic bus_cmd_t fetch_cmd(input logic [REG_BUS_W-1:0] addr);
        bus_cmd_t c;
        c.we    = 1'b0;
        c.sel   = FETCH_SEL;
        c.addr  = addr;
        c.wdata = '0;
        return c;
    endfunction

    function automatic bus_cmd_t data_cmd(
        input logic                 we,
        input logic [SEL_W-1:0]     sel,
        input logic [REG_BUS_W-1:0] addr,
        input logic [REG_BUS_W-1:0] wdata
    );
        bus_cmd_t c;
        c.we    = we;
        c.sel   = sel;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one req/ack memory bus between the fetch and data ports, holding each
// port's stall request until its result has been consumed by the pipeline.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 if_ce_i,
    input  logic [REG_BUS_W-1:0] if_addr_i,
    output logic [REG_BUS_W-1:0] if_data_o,
    output logic                 if_stallreq_o,
    input  logic                 if_hold_i,

    input  logic                 mem_ce_i,
    input  logic                 mem_we_i,
    input  logic [SEL_W-1:0]     mem_sel_i,
    input  logic [REG_BUS_W-1:0] mem_addr_i,
    input  logic [REG_BUS_W-1:0] mem_data_i,
    output logic [REG_BUS_W-1:0] mem_data_o,
    output logic                 mem_stallreq_o,
    input  logic                 mem_hold_i,

    input  logic                 flush_i,

    output logic                 bus_req_o,
    output logic                 bus_we_o,
    output logic [SEL_W-1:0]     bus_sel_o,
    output logic [REG_BUS_W-1:0] bus_addr_o,
    output logic [REG_BUS_W-1:0] bus_wdata_o,
    input  logic                 bus_ack_i,
    input  logic [REG_BUS_W-1:0] bus_rdata_i
);

    arb_state_e           state_q, state_d;
    logic                 i_done_q, i_done_d;
    logic                 d_done_q, d_done_d;
    logic                 bus_req_q, bus_req_d;
    bus_cmd_t             cmd_q, cmd_d;
    logic [REG_BUS_W-1:0] if_data_q, if_data_d;
    logic [REG_BUS_W-1:0] mem_data_q, mem_data_d;

    logic                 if_elig;
    logic                 mem_elig;
    logic                 issue_data;
    logic                 issue_fetch;

    // Stall requests must not look at the hold inputs, or ctrl closes a loop.
    always_comb begin
        if_elig        = if_ce_i && !i_done_q;
        mem_elig       = mem_ce_i && !d_done_q;
        if_stallreq_o  = !rst && if_elig;
        mem_stallreq_o = !rst && mem_elig;
    end

    always_comb begin
        state_d    = state_q;
        bus_req_d  = bus_req_q;
        cmd_d      = cmd_q;
        if_data_d  = if_data_q;
        mem_data_d = mem_data_q;

        i_done_d    = i_done_q && if_hold_i;
        d_done_d    = d_done_q && mem_hold_i;
        issue_data  = mem_elig && (DATA_FIRST || !if_elig);
        issue_fetch = if_elig && !issue_data;

        unique case (state_q)
            ARB_IDLE: begin
                if (!flush_i) begin
                    if (issue_data) begin
                        cmd_d     = data_cmd(mem_we_i, mem_sel_i, mem_addr_i, mem_data_i);
                        bus_req_d = 1'b1;
                        state_d   = ARB_DBUS;
                    end else if (issue_fetch) begin
                        cmd_d     = fetch_cmd(if_addr_i);
                        bus_req_d = 1'b1;
                        state_d   = ARB_IBUS;
                    end
                end
            end
            ARB_IBUS, ARB_DBUS: begin
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    state_d   = ARB_IDLE;
                    // An ack coinciding with a flush belongs to a squashed access.
                    if (!flush_i) begin
                        if (state_q == ARB_IBUS) begin
                            if_data_d = bus_rdata_i;
                            i_done_d  = 1'b1;
                        end else begin
                            mem_data_d = bus_rdata_i;
                            d_done_d   = 1'b1;
                        end
                    end
                end else if (flush_i) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    state_d   = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (flush_i) begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            bus_req_q  <= 1'b0;
            cmd_q      <= '0;
            if_data_q  <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            i_done_q   <= i_done_d;
            d_done_q   <= d_done_d;
            bus_req_q  <= bus_req_d;
            cmd_q      <= cmd_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = cmd_q.we;
    assign bus_sel_o   = cmd_q.sel;
    assign bus_addr_o  = cmd_q.addr;
    assign bus_wdata_o = cmd_q.wdata;
    assign if_data_o   = if_data_q;
    assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle vectors followed by randomized traffic
// checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam bit DF = 1'b1;
    localparam bit L  = 1'b0;
    localparam bit H  = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i, if_hold_i;
    logic [31:0] if_addr_i, if_data_o;
    logic        if_stallreq_o;
    logic        mem_ce_i, mem_we_i, mem_hold_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
    logic        mem_stallreq_o;
    logic        flush_i;
    logic        bus_req_o, bus_we_o, bus_ack_i;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_FIRST(DF)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_ce_i       (if_ce_i),
        .if_addr_i     (if_addr_i),
        .if_data_o     (if_data_o),
        .if_stallreq_o (if_stallreq_o),
        .if_hold_i     (if_hold_i),
        .mem_ce_i      (mem_ce_i),
        .mem_we_i      (mem_we_i),
        .mem_sel_i     (mem_sel_i),
        .mem_addr_i    (mem_addr_i),
        .mem_data_i    (mem_data_i),
        .mem_data_o    (mem_data_o),
        .mem_stallreq_o(mem_stallreq_o),
        .mem_hold_i    (mem_hold_i),
        .flush_i       (flush_i),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_sel_o     (bus_sel_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_ack_i     (bus_ack_i),
        .bus_rdata_i   (bus_rdata_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One record per cycle: inputs, then combinational stalls, then registered outputs after the edge.
    typedef struct {
        bit rst; bit if_ce; logic [31:0] if_addr; bit if_hold;
        bit mem_ce; bit mem_we; logic [3:0] mem_sel; logic [31:0] mem_addr; logic [31:0] mem_wdata; bit mem_hold;
        bit flush; bit ack; logic [31:0] rdata;
        bit e_ifs; bit e_ms;
        bit e_req; bit e_we; logic [3:0] e_sel; logic [31:0] e_addr; logic [31:0] e_wdata;
        logic [31:0] e_ifd; logic [31:0] e_md;
    } vec_t;
    vec_t vecs[$];

    // Reference model: at most one outstanding transaction, kept as a queue entry.
    typedef struct { bit is_data; bit discard; } txn_t;
    typedef struct { logic we; logic [3:0] sel; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
    txn_t        inflight[$];
    cmd_t        m_cmd;
    bit          m_i_done, m_d_done;
    logic [31:0] m_if_data, m_mem_data;

    task automatic model_step();
        bit   set_i, set_d, want_i, want_d;
        txn_t t;
        set_i = 1'b0;
        set_d = 1'b0;
        if (rst) begin
            inflight.delete();
            m_cmd      = '{1'b0, 4'h0, 32'h0, 32'h0};
            m_i_done   = 1'b0;
            m_d_done   = 1'b0;
            m_if_data  = 32'h0;
            m_mem_data = 32'h0;
        end else begin
            if (inflight.size() != 0) begin
                if (bus_ack_i) begin
                    t = inflight.pop_front();
                    if (!t.discard && !flush_i) begin
                        if (t.is_data) begin m_mem_data = bus_rdata_i; set_d = 1'b1; end
                        else           begin m_if_data  = bus_rdata_i; set_i = 1'b1; end
                    end
                end else if (flush_i) begin
                    inflight[0].discard = 1'b1;
                end
            end else if (!flush_i) begin
                want_d = mem_ce_i && !m_d_done;
                want_i = if_ce_i && !m_i_done;
                if (want_d && (DF || !want_i)) begin
                    inflight.push_back('{1'b1, 1'b0});
                    m_cmd = '{mem_we_i, mem_sel_i, mem_addr_i, mem_data_i};
                end else if (want_i) begin
                    inflight.push_back('{1'b0, 1'b0});
                    m_cmd = '{1'b0, 4'hF, if_addr_i, 32'h0};
                end
            end
            m_i_done = flush_i ? 1'b0 : (set_i ? 1'b1 : (m_i_done && if_hold_i));
            m_d_done = flush_i ? 1'b0 : (set_d ? 1'b1 : (m_d_done && mem_hold_i));
        end
    endtask

    initial begin
        vec_t v;

        // reset, with requests present to show stalls are forced low
        vecs.push_back('{H,H,32'h40,L, H,L,4'h0,32'h0,32'h0,L, L,L,32'h0, L,L, L,L,4'h0,32'h0,32'h0,32'h0,32'h0});
        // fetch 0x40, ack in first req cycle
        vecs.push_back('{L,H,32'h40,H, L,L,4'h0,32'h0,32'h0,L, L,L,32'h0, H,L, H,L,4'hF,32'h40,32'h0,32'h0,32'h0});
        vecs.push_back('{L,H,32'h40,H, L,L,4'h0,32'h0,32'h0,L, L,H,32'h24010005, H,L, L,L,4'hF,32'h40,32'h0,32'h24010005,32'h0});
        vecs.push_back('{L,H,32'h40,L, L,L,4'h0,32'h0,32'h0,L, L,L,32'h0, L,L, L,L,4'hF,32'h40,32'h0,32'h24010005,32'h0});
        vecs.push_back('{L,L,32'h0,L, L,L,4'h0,32'h0,32'h0,L, L,L,32'h0, L,L, L,L,4'hF,32'h40,32'h0,32'h24010005,32'h0});
        // store sel 0011, four wait cycles
        for (int k = 0; k < 5; k++)
            vecs.push_back('{L,L,32'h0,L, H,H,4'h3,32'h100,32'hDEADBEEF,H, L,L,32'h0, L,H, H,H,4'h3,32'h100,32'hDEADBEEF,32'h24010005,32'h0});
        vecs.push_back('{L,L,32'h0,L, H,H,4'h3,32'h100,32'hDEADBEEF,H, L,H,32'h11112222, L,H, L,H,4'h3,32'h100,32'hDEADBEEF,32'h24010005,32'h11112222});
        vecs.push_back('{L,L,32'h0,L, H,H,4'h3,32'h100,32'hDEADBEEF,L, L,L,32'h0, L,L, L,H,4'h3,32'h100,32'hDEADBEEF,32'h24010005,32'h11112222});
        vecs.push_back('{L,L,32'h0,L, L,L,4'h0,32'h0,32'h0,L, L,L,32'h0, L,L, L,H,4'h3,32'h100,32'hDEADBEEF,32'h24010005,32'h11112222});
        // fetch and load together, data first, ack on third req cycle
        for (int k = 0; k < 3; k++)
            vecs.push_back('{L,H,32'h44,H, H,L,4'hF,32'h200,32'h0,H, L,L,32'h0, H,H, H,L,4'hF,32'h200,32'h0,32'h24010005,32'h11112222});
        vecs.push_back('{L,H,32'h44,H, H,L,4'hF,32'h200,32'h0,H, L,H,32'hCAFE0001, H,H, L,L,4'hF,32'h200,32'h0,32'h24010005,32'hCAFE0001});
        for (int k = 0; k < 3; k++)
            vecs.push_back('{L,H,32'h44,H, H,L,4'hF,32'h200,32'h0,H, L,L,32'h0, H,L, H,L,4'hF,32'h44,32'h0,32'h24010005,32'hCAFE0001});
        vecs.push_back('{L,H,32'h44,H, H,L,4'hF,32'h200,32'h0,H, L,H,32'h8C220004, H,L, L,L,4'hF,32'h44,32'h0,32'h8C220004,32'hCAFE0001});
        vecs.push_back('{L,H,32'h44,L, H,L,4'hF,32'h200,32'h0,L, L,L,32'h0, L,L, L,L,4'hF,32'h44,32'h0,32'h8C220004,32'hCAFE0001});
        vecs.push_back('{L,L,32'h0,L, L,L,4'h0,32'h0,32'h0,L, L,L,32'h0, L,L, L,L,4'hF,32'h44,32'h0,32'h8C220004,32'hCAFE0001});
        // load completes under a three-cycle hold: no re-issue, data stable
        vecs.push_back('{L,L,32'h0,L, H,L,4'hF,32'h300,32'h0,H, L,L,32'h0, L,H, H,L,4'hF,32'h300,32'h0,32'h8C220004,32'hCAFE0001});
        vecs.push_back('{L,L,32'h0,L, H,L,4'hF,32'h300,32'h0,H, L,H,32'h55AA55AA, L,H, L,L,4'hF,32'h300,32'h0,32'h8C220004,32'h55AA55AA});
        for (int k = 0; k < 3; k++)
            vecs.push_back('{L,L,32'h0,L, H,L,4'hF,32'h300,32'h0,H, L,L,32'hFFFFFFFF, L,L, L,L,4'hF,32'h300,32'h0,32'h8C220004,32'h55AA55AA});
        vecs.push_back('{L,L,32'h0,L, H,L,4'hF,32'h300,32'h0,L, L,L,32'h0, L,L, L,L,4'hF,32'h300,32'h0,32'h8C220004,32'h55AA55AA});
        // flush during a data wait, then a fetch to the exception vector
        vecs.push_back('{L,L,32'h0,L, H,L,4'hF,32'h304,32'h0,H, L,L,32'h0, L,H, H,L,4'hF,32'h304,32'h0,32'h8C220004,32'h55AA55AA});
        vecs.push_back('{L,L,32'h0,L, H,L,4'hF,32'h304,32'h0,H, H,L,32'h0, L,H, H,L,4'hF,32'h304,32'h0,32'h8C220004,32'h55AA55AA});
        vecs.push_back('{L,H,32'hBFC00380,H, L,L,4'h0,32'h0,32'h0,L, L,L,32'h0, H,L, H,L,4'hF,32'h304,32'h0,32'h8C220004,32'h55AA55AA});
        vecs.push_back('{L,H,32'hBFC00380,H, L,L,4'h0,32'h0,32'h0,L, L,H,32'h12345678, H,L, L,L,4'hF,32'h304,32'h0,32'h8C220004,32'h55AA55AA});
        vecs.push_back('{L,H,32'hBFC00380,H, L,L,4'h0,32'h0,32'h0,L, L,L,32'h0, H,L, H,L,4'hF,32'hBFC00380,32'h0,32'h8C220004,32'h55AA55AA});
        // reset during a fetch
        for (int k = 0; k < 2; k++)
            vecs.push_back('{H,H,32'hBFC00380,H, L,L,4'h0,32'h0,32'h0,L, L,L,32'h0, L,L, L,L,4'h0,32'h0,32'h0,32'h0,32'h0});
        // flush and ack in the same cycle discards the result
        vecs.push_back('{L,L,32'h0,L, H,L,4'hF,32'h400,32'h0,H, L,L,32'h0, L,H, H,L,4'hF,32'h400,32'h0,32'h0,32'h0});
        vecs.push_back('{L,L,32'h0,L, H,L,4'hF,32'h400,32'h0,H, H,H,32'h77777777, L,H, L,L,4'hF,32'h400,32'h0,32'h0,32'h0});
        vecs.push_back('{L,L,32'h0,L, H,L,4'hF,32'h400,32'h0,H, L,L,32'h0, L,H, H,L,4'hF,32'h400,32'h0,32'h0,32'h0});
        vecs.push_back('{L,L,32'h0,L, H,L,4'hF,32'h400,32'h0,H, L,H,32'h9, L,H, L,L,4'hF,32'h400,32'h0,32'h0,32'h9});
        vecs.push_back('{L,L,32'h0,L, L,L,4'h0,32'h0,32'h0,L, L,L,32'h0, L,L, L,L,4'hF,32'h400,32'h0,32'h0,32'h9});

        foreach (vecs[i]) begin
            v           = vecs[i];
            rst         = v.rst;
            if_ce_i     = v.if_ce;
            if_addr_i   = v.if_addr;
            if_hold_i   = v.if_hold;
            mem_ce_i    = v.mem_ce;
            mem_we_i    = v.mem_we;
            mem_sel_i   = v.mem_sel;
            mem_addr_i  = v.mem_addr;
            mem_data_i  = v.mem_wdata;
            mem_hold_i  = v.mem_hold;
            flush_i     = v.flush;
            bus_ack_i   = v.ack;
            bus_rdata_i = v.rdata;
            #1;
            check($sformatf("v%0d if_stallreq", i), {31'h0, if_stallreq_o}, {31'h0, v.e_ifs});
            check($sformatf("v%0d mem_stallreq", i), {31'h0, mem_stallreq_o}, {31'h0, v.e_ms});
            @(posedge clk);
            #1;
            check($sformatf("v%0d bus_req", i), {31'h0, bus_req_o}, {31'h0, v.e_req});
            check($sformatf("v%0d bus_we", i), {31'h0, bus_we_o}, {31'h0, v.e_we});
            check($sformatf("v%0d bus_sel", i), {28'h0, bus_sel_o}, {28'h0, v.e_sel});
            check($sformatf("v%0d bus_addr", i), bus_addr_o, v.e_addr);
            check($sformatf("v%0d bus_wdata", i), bus_wdata_o, v.e_wdata);
            check($sformatf("v%0d if_data", i), if_data_o, v.e_ifd);
            check($sformatf("v%0d mem_data", i), mem_data_o, v.e_md);
        end

        // randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            rst         = (c < 2) || ($urandom_range(0, 199) == 0);
            if_ce_i     = $urandom_range(0, 1) == 1;
            if_addr_i   = $urandom;
            if_hold_i   = $urandom_range(0, 1) == 1;
            mem_ce_i    = $urandom_range(0, 1) == 1;
            mem_we_i    = $urandom_range(0, 1) == 1;
            mem_sel_i   = 4'($urandom_range(0, 15));
            mem_addr_i  = $urandom;
            mem_data_i  = $urandom;
            mem_hold_i  = $urandom_range(0, 1) == 1;
            flush_i     = $urandom_range(0, 29) == 0;
            bus_ack_i   = bus_req_o && ($urandom_range(0, 2) == 0);
            bus_rdata_i = $urandom;
            #1;
            check($sformatf("r%0d if_stallreq", c), {31'h0, if_stallreq_o},
                  {31'h0, !rst && if_ce_i && !m_i_done});
            check($sformatf("r%0d mem_stallreq", c), {31'h0, mem_stallreq_o},
                  {31'h0, !rst && mem_ce_i && !m_d_done});
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("r%0d bus_req", c), {31'h0, bus_req_o}, {31'h0, inflight.size() != 0});
            check($sformatf("r%0d bus_we", c), {31'h0, bus_we_o}, {31'h0, m_cmd.we});
            check($sformatf("r%0d bus_sel", c), {28'h0, bus_sel_o}, {28'h0, m_cmd.sel});
            check($sformatf("r%0d bus_addr", c), bus_addr_o, m_cmd.addr);
            check($sformatf("r%0d bus_wdata", c), bus_wdata_o, m_cmd.wdata);
            check($sformatf("r%0d if_data", c), if_data_o, m_if_data);
            check($sformatf("r%0d mem_data", c), mem_data_o, m_mem_data);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
